// File: rtl/collision_reader.sv
// Scans a SPRITE_W x SPRITE_H framebuffer region through a synchronous-read port and
// reports whether any on-screen pixel differs from a key colour, how many do, and the first one.
module collision_reader #(
   parameter int unsigned SPRITE_W = 8,
   parameter int unsigned SPRITE_H = 8,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] refX,
   input  logic [6:0] refY,
   input  logic [2:0] keyColour,
   output logic [7:0] rdX,
   output logic [6:0] rdY,
   output logic       rdEn,
   input  logic [2:0] rdData,
   output logic       done,
   output logic       hit,
   output logic [6:0] hitCount,
   output logic [2:0] firstHitX,
   output logic [2:0] firstHitY
);

   localparam int unsigned XW    = $clog2(SPRITE_W);
   localparam int unsigned YW    = $clog2(SPRITE_H);
   localparam int unsigned IW    = XW + YW;
   localparam int unsigned SLOTS = SPRITE_W * SPRITE_H;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [7:0]      refx_q, refx_d;
   logic [6:0]      refy_q, refy_d;
   logic [2:0]      key_q, key_d;
   logic [7:0]      rdx_q, rdx_d;
   logic [6:0]      rdy_q, rdy_d;
   logic            rden_q, rden_d;
   logic            v2_q, v2_d;
   logic [IW-1:0]   off2_q, off2_d;
   logic            done_q, done_d;
   logic            hit_q, hit_d;
   logic [6:0]      count_q, count_d;
   logic [XW-1:0]   fx_q, fx_d;
   logic [YW-1:0]   fy_q, fy_d;

   logic            present;
   logic [7:0]      base_x;
   logic [6:0]      base_y;
   logic [8:0]      sum_x;
   logic [7:0]      sum_y;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         refx_q  <= '0;
         refy_q  <= '0;
         key_q   <= '0;
         rdx_q   <= '0;
         rdy_q   <= '0;
         rden_q  <= 1'b0;
         v2_q    <= 1'b0;
         off2_q  <= '0;
         done_q  <= 1'b1;
         hit_q   <= 1'b0;
         count_q <= '0;
         fx_q    <= '0;
         fy_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         refx_q  <= refx_d;
         refy_q  <= refy_d;
         key_q   <= key_d;
         rdx_q   <= rdx_d;
         rdy_q   <= rdy_d;
         rden_q  <= rden_d;
         v2_q    <= v2_d;
         off2_q  <= off2_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         count_q <= count_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      refx_d  = refx_q;
      refy_d  = refy_q;
      key_d   = key_q;
      rdx_d   = '0;
      rdy_d   = '0;
      rden_d  = 1'b0;
      v2_d    = rden_q;
      off2_d  = cnt_q;
      done_d  = done_q;
      hit_d   = hit_q;
      count_d = count_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      present = 1'b0;
      base_x  = refx_q;
      base_y  = refy_q;
      sum_x   = '0;
      sum_y   = '0;

      // Second pipeline stage: rdData belongs to the slot presented two edges ago.
      if (v2_q && (rdData != key_q)) begin
         count_d = count_q + 7'd1;
         hit_d   = 1'b1;
         if (!hit_q) begin
            fx_d = off2_q[XW-1:0];
            fy_d = off2_q[IW-1:XW];
         end
      end

      case (state_q)
         IDLE: ;
         SCAN: begin
            if (cnt_q == IW'(SLOTS - 1)) begin
               state_d = DRAIN;
            end else begin
               cnt_d   = cnt_q + IW'(1);
               present = 1'b1;
            end
         end
         DRAIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A start pulse restarts from slot 0 regardless of state, dropping in-flight data.
      if (start) begin
         state_d = SCAN;
         refx_d  = refX;
         refy_d  = refY;
         key_d   = keyColour;
         cnt_d   = '0;
         v2_d    = 1'b0;
         done_d  = 1'b0;
         hit_d   = 1'b0;
         count_d = '0;
         fx_d    = '0;
         fy_d    = '0;
         present = 1'b1;
         base_x  = refX;
         base_y  = refY;
      end

      if (present) begin
         sum_x = {1'b0, base_x} + 9'(cnt_d[XW-1:0]);
         sum_y = {1'b0, base_y} + 8'(cnt_d[IW-1:XW]);
         if ((sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H))) begin
            rden_d = 1'b1;
            rdx_d  = sum_x[7:0];
            rdy_d  = sum_y[6:0];
         end
      end
   end

   assign rdX       = rdx_q;
   assign rdY       = rdy_q;
   assign rdEn      = rden_q;
   assign done      = done_q;
   assign hit       = hit_q;
   assign hitCount  = count_q;
   assign firstHitX = 3'(fx_q);
   assign firstHitY = 3'(fy_q);

endmodule

// File: tb/tb_collision_reader.sv
// Randomised and directed bench for collision_reader against a framebuffer
// memory model and a loop-based reference of the scan results.
module tb_collision_reader;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] refX;
   logic [6:0] refY;
   logic [2:0] keyColour;
   logic [7:0] rdX;
   logic [6:0] rdY;
   logic       rdEn;
   logic [2:0] rdData;
   logic       done;
   logic       hit;
   logic [6:0] hitCount;
   logic [2:0] firstHitX;
   logic [2:0] firstHitY;

   logic [2:0] fb [0:255][0:127];

   int checks;
   int errors;
   int got_q[$];
   int exp_q[$];
   int viol;
   int got_base;
   int viol_base;
   int e_cnt, e_fx, e_fy;

   collision_reader dut (
      .clock(clock), .reset(reset), .start(start),
      .refX(refX), .refY(refY), .keyColour(keyColour),
      .rdX(rdX), .rdY(rdY), .rdEn(rdEn), .rdData(rdData),
      .done(done), .hit(hit), .hitCount(hitCount),
      .firstHitX(firstHitX), .firstHitY(firstHitY)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous-read framebuffer; garbage when no read is requested.
   always @(posedge clock) rdData <= rdEn ? fb[rdX][rdY] : 3'($urandom);

   always @(negedge clock) begin
      if (rdEn) got_q.push_back(int'({rdX, rdY}));
      else if (rdX != 8'd0 || rdY != 7'd0) viol++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input int c);
      for (int x = 0; x < 256; x++)
         for (int y = 0; y < 128; y++)
            fb[x][y] = 3'(c);
   endtask

   task automatic model(input int rx, input int ry, input int key);
      exp_q.delete();
      e_cnt = 0; e_fx = 0; e_fy = 0;
      for (int yi = 0; yi < 8; yi++) begin
         for (int xi = 0; xi < 8; xi++) begin
            int x, y;
            x = rx + xi;
            y = ry + yi;
            if (x < 160 && y < 120) begin
               exp_q.push_back(x * 128 + y);
               if (int'(fb[x][y]) != key) begin
                  if (e_cnt == 0) begin e_fx = xi; e_fy = yi; end
                  e_cnt++;
               end
            end
         end
      end
   endtask

   task automatic start_pulse(input int rx, input int ry, input int key);
      model(rx, ry, key);
      @(negedge clock);
      start = 1'b1; refX = 8'(rx); refY = 7'(ry); keyColour = 3'(key);
      @(posedge clock);
      #1;
      start = 1'b0; refX = 8'($urandom); refY = 7'($urandom); keyColour = 3'($urandom);
      got_base  = got_q.size();
      viol_base = viol;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!done && n < 200);
      check("latency", n, 65);
   endtask

   task automatic check_results();
      int nr;
      check("hit", int'(hit), int'(e_cnt > 0));
      check("hitCount", int'(hitCount), e_cnt);
      check("firstHitX", int'(firstHitX), e_fx);
      check("firstHitY", int'(firstHitY), e_fy);
      nr = got_q.size() - got_base;
      check("nreads", nr, exp_q.size());
      for (int i = 0; i < nr && i < exp_q.size(); i++)
         check("rd_xy", got_q[got_base + i], exp_q[i]);
      check("rd_idle_zero", viol - viol_base, 0);
   endtask

   task automatic run_scan(input int rx, input int ry, input int key);
      start_pulse(rx, ry, key);
      wait_done();
      check_results();
   endtask

   initial begin
      int n;
      checks = 0; errors = 0; viol = 0; got_base = 0; viol_base = 0;
      reset = 1'b1; start = 1'b0; refX = '0; refY = '0; keyColour = '0;
      fill(0);
      #1;
      check("rst_done", int'(done), 1);
      check("rst_rdEn", int'(rdEn), 0);
      check("rst_hitCount", int'(hitCount), 0);
      @(negedge clock);
      reset = 1'b0;

      // Uniform background: no hits, full raster sweep.
      fill(0);
      run_scan(20, 30, 0);

      // One differing pixel.
      fb[23][32] = 3'b100;
      run_scan(20, 30, 0);

      // Bottom-right corner: only 4x4 slots on-screen.
      fill(7);
      run_scan(156, 116, 0);

      // Every pixel hits.
      fill(2);
      run_scan(0, 0, 0);

      // Restart mid-scan with a new region.
      fill(0);
      for (int x = 20; x < 28; x++)
         for (int y = 30; y < 38; y++)
            fb[x][y] = 3'd5;
      fb[53][62] = 3'd6;
      fb[57][61] = 3'd1;
      start_pulse(20, 30, 0);
      repeat (30) @(posedge clock);
      start_pulse(50, 60, 0);
      check("restart_rdX", int'(rdX), 50);
      check("restart_rdY", int'(rdY), 60);
      check("restart_rdEn", int'(rdEn), 1);
      wait_done();
      check_results();

      // Restart coinciding with the final drain edge.
      fill(0);
      fb[20][30] = 3'd3;
      fb[101][51] = 3'd5;
      start_pulse(20, 30, 0);
      repeat (64) @(posedge clock);
      start_pulse(100, 50, 0);
      check("final_edge_done", int'(done), 0);
      wait_done();
      check_results();

      // Reset in the middle of a scan.
      fill(7);
      start_pulse(20, 30, 0);
      repeat (40) @(posedge clock);
      #1;
      check("pre_rst_hitCount", int'(hitCount), 39);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_rdEn", int'(rdEn), 0);
      check("mid_rst_done", int'(done), 1);
      check("mid_rst_hit", int'(hit), 0);
      check("mid_rst_hitCount", int'(hitCount), 0);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         if (rdEn || !done) n++;
      end
      check("post_rst_idle", n, 0);

      // Random content, references and keys, including off-screen origins.
      for (int it = 0; it < 12; it++) begin
         int key;
         key = int'($urandom_range(0, 7));
         for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
               fb[x][y] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(key);
         run_scan(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)), key);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/collision_reader.md
Name: collision_reader

Overview:
- Read-side counterpart of the sprite drawers: scans an 8x8 framebuffer region at (refX, refY) through a synchronous-read framebuffer port.
- Compares every pixel against a background key colour and reports whether any non-background pixel is present, how many there are, and where the first one is.
- Runs before a sprite is drawn, for player/obstacle collision detection; one scan per start pulse.

Parameters:
- SPRITE_W, 8, region width in pixels (power of two)
- SPRITE_H, 8, region height in pixels (power of two)
- SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen
- SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins or restarts a scan
- refX  in  8  region top-left x, sampled on the start edge
- refY  in  7  region top-left y, sampled on the start edge
- keyColour  in  3  background colour, sampled on the start edge
- rdX  out  8  framebuffer read x (registered)
- rdY  out  7  framebuffer read y (registered)
- rdEn  out  1  read request valid for rdX/rdY (registered)
- rdData  in  3  pixel colour; valid the cycle after the cycle in which rdEn/rdX/rdY were presented
- done  out  1  high when idle with results valid
- hit  out  1  at least one on-screen pixel != keyColour
- hitCount  out  7  number of such pixels, 0..64
- firstHitX  out  3  x offset of the first hit in raster order
- firstHitY  out  3  y offset of the first hit in raster order

Behaviour:
- Reset (async, any state): state IDLE; rdEn=0, rdX=0, rdY=0, done=1, hit=0, hitCount=0, firstHitX=0, firstHitY=0.
- States: IDLE, SCAN, DRAIN.
- IDLE: outputs hold. start=1 -> SCAN. On that edge: latch refX/refY/keyColour, clear hit/hitCount/firstHit*, done=0, and present slot 0.
- SCAN: slot k (k = yi*SPRITE_W + xi, xi fastest) is presented in the cycle after edge E_k, k=0..63.
  - rdX = refX + xi and rdY = refY + yi, computed at 9 and 8 bits.
  - If either sum >= SCREEN_W / SCREEN_H, the slot is off-screen: rdEn=0, rdX=0, rdY=0, and the slot is marked invalid in a 1-bit valid pipeline.
  - Otherwise rdEn=1.
  - After slot 63 is presented -> DRAIN.
- Compare pipeline: data for slot k is sampled at edge E_{k+2} only if slot k was valid.
  - If rdData != latched keyColour: hitCount += 1, hit = 1.
  - If this is the first hit of the scan, firstHitX/Y = slot offsets.
- DRAIN: rdEn=0. Samples slot 62 data at E64 and slot 63 data at E65. At E65: done=1, state IDLE.
- Latency: done rises at edge E65 after the start-sampling edge E0, i.e. 65 cycles. Results are final when done=1.
- start while in SCAN or DRAIN: abort the scan, discard partial results and in-flight data (clear the valid pipeline), restart from slot 0 with newly sampled inputs. done stays 0.
- start in the same cycle as the final DRAIN edge: the restart wins; done stays 0.
- hitCount cannot overflow (max 64 < 128). When hit=0, firstHitX/Y = 0.
- Inputs other than rdData are ignored outside the start edge.

Test Plan:
- All 64 pixels equal key 3'b000, refX=20, refY=30, start pulse -> rdEn high for 64 consecutive cycles, rdX/rdY sweep 20..27/30..37 in raster order; done at E65; hit=0, hitCount=0.
- Single pixel 3'b100 at (23,32), key 0, ref (20,30) -> hit=1, hitCount=1, firstHitX=3, firstHitY=2.
- refX=156, refY=116, every framebuffer pixel 3'b111, key 0 -> rdEn high only for the 16 slots with xi<4 and yi<4; hitCount=16; firstHit (0,0).
- Every pixel 3'b010, key 0, ref (0,0) -> hitCount=64, hit=1, firstHit (0,0); done exactly 65 cycles after start.
- Second start at slot 30 with new ref (50,60) -> scan restarts, rdX=50, rdY=60 next cycle; results reflect only the second region; done 65 cycles after the second start.
- reset asserted mid-scan (slot 40) -> same cycle rdEn=0, done=1, hit=0, hitCount=0; no further reads until a new start.
